sm4_sched: RTL

Two-requester scheduler for the SM4 32-round pipelined encrypt/decrypt datapath. Each requester presents 128-bit blocks together with its own 1024-bit expanded round-key set; the block-order key reversal for decryption is already applied by the requester. The datapath applies all 32 round keys from one unregistered bus, so the key must stay constant while any block is in flight. This block arbitrates between the two requesters, drives the datapath's key, data and valid inputs, drains the pipeline before every owner change, and routes results back to the owner.

---
 rtl/sm4_pkg.sv | 14 +
 rtl/sm4_rr_pick.sv | 26 ++
 rtl/sm4_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sm4_pkg.sv
// Shared SM4 widths and the scheduler state encoding.
package sm4_pkg;

    localparam int unsigned SM4_BLK_W  = 128;
    localparam int unsigned SM4_RK_W   = 1024;
    localparam int unsigned SM4_ROUNDS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

endpackage

// File: rtl/sm4_rr_pick.sv
// Two-way owner pick: idle-time choice honouring the last owner, plus the
// burst-limit / owner-drop switch request while running.
module sm4_rr_pick (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic owner_i,
    input  logic last_i,
    input  logic burst_full_i,
    output logic pick_o,
    output logic switch_o,
    output logic hold_o
);

    logic owner_vld;
    logic other_vld;

    always_comb begin
        owner_vld = owner_i ? valid1_i : valid0_i;
        other_vld = owner_i ? valid0_i : valid1_i;
        // Prefer the requester that was not served last; fall back to the last one.
        pick_o    = (last_i ? valid0_i : valid1_i) ? ~last_i : last_i;
        hold_o    = burst_full_i && other_vld;
        switch_o  = other_vld && (!owner_vld || burst_full_i);
    end

endmodule

// File: rtl/sm4_sched.sv
// Scheduler for two requesters sharing one SM4 pipeline whose round-key bus
// is unregistered: the owner only changes once the pipeline is empty.
module sm4_sched
    import sm4_pkg::*;
#(
    parameter int unsigned LAT   = 32,
    parameter int unsigned BURST = 8
) (
    input  logic                 CLK_i,
    input  logic                 RST_i,
    input  logic                 REQ0_VALID_i,
    input  logic [SM4_BLK_W-1:0] REQ0_DAT_i,
    input  logic [SM4_RK_W-1:0]  REQ0_RK_i,
    output logic                 REQ0_READY_o,
    input  logic                 REQ1_VALID_i,
    input  logic [SM4_BLK_W-1:0] REQ1_DAT_i,
    input  logic [SM4_RK_W-1:0]  REQ1_RK_i,
    output logic                 REQ1_READY_o,
    output logic                 KEY_BUSY0_o,
    output logic                 KEY_BUSY1_o,
    output logic                 RSP0_VALID_o,
    output logic                 RSP1_VALID_o,
    output logic [SM4_BLK_W-1:0] RSP_DAT_o,
    output logic [SM4_RK_W-1:0]  SM_RK_o,
    output logic [SM4_BLK_W-1:0] SM_DAT_o,
    output logic                 SM_VALID_o,
    input  logic [SM4_BLK_W-1:0] SM_DAT_i,
    input  logic                 SM_READY_i,
    output logic                 ERR_o
);

    localparam int unsigned CNT_W  = $clog2(LAT + 1);
    localparam int unsigned BCNT_W = $clog2(BURST + 1);

    sched_state_e      state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

    logic any_vld, owner_vld, cnt_zero, burst_full;
    logic pick, switch_req, hold, grant, accept, rsp_ok;

    assign any_vld    = REQ0_VALID_i || REQ1_VALID_i;
    assign cnt_zero   = (cnt_q == '0);
    assign burst_full = (bcnt_q == BCNT_W'(BURST));
    assign ERR_o      = err_q;

    sm4_rr_pick u_pick (
        .valid0_i     (REQ0_VALID_i),
        .valid1_i     (REQ1_VALID_i),
        .owner_i      (owner_q),
        .last_i       (last_q),
        .burst_full_i (burst_full),
        .pick_o       (pick),
        .switch_o     (switch_req),
        .hold_o       (hold)
    );

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        cnt_d   = cnt_q;
        if (accept && !SM_READY_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accept && SM_READY_i && !cnt_zero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        err_d = err_q || (SM_READY_i && cnt_zero) || (accept && cnt_q == CNT_W'(LAT));
        case (state_q)
            ST_IDLE: begin
                if (any_vld) begin
                    owner_d = pick;
                    bcnt_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && !burst_full) begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
                if (switch_req) begin
                    state_d = ST_DRAIN;
                end else if (!any_vld && cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Hand over on the edge that retires the last in-flight block.
                if (cnt_d == '0) begin
                    last_d  = owner_q;
                    owner_d = ~owner_q;
                    bcnt_d  = '0;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        owner_vld    = owner_q ? REQ1_VALID_i : REQ0_VALID_i;
        grant        = (state_q == ST_RUN) && (cnt_q < CNT_W'(LAT)) && !hold;
        accept       = grant && owner_vld;
        REQ0_READY_o = grant && !owner_q;
        REQ1_READY_o = grant && owner_q;
        SM_VALID_o   = accept;
        SM_DAT_o     = owner_q ? REQ1_DAT_i : REQ0_DAT_i;
        SM_RK_o      = owner_q ? REQ1_RK_i : REQ0_RK_i;
        // A result with nothing in flight is an error, never a response.
        rsp_ok       = SM_READY_i && !cnt_zero;
        RSP0_VALID_o = rsp_ok && !owner_q;
        RSP1_VALID_o = rsp_ok && owner_q;
        RSP_DAT_o    = SM_DAT_i;
        KEY_BUSY0_o  = !owner_q && !cnt_zero;
        KEY_BUSY1_o  = owner_q && !cnt_zero;
    end

    a_no_overflow: assert property (@(posedge CLK_i) disable iff (RST_i)
        !(accept && cnt_q == CNT_W'(LAT)));

endmodule
